turbo_output_buffer: RTL
========================

TURBO_OUTPUT_BUFFER -- requirements
Module: turbo_output_buffer

Interface
REQ-001 SHALL have parameter K_SHORT, default 1056: short-block length in triplets (in_length=0).
REQ-002 SHALL have parameter K_LONG, default 6144: long-block length in triplets (in_length=1); K_LONG >= K_SHORT.
REQ-003 SHALL have parameter TRL_LEN, default 4: termination triplets per block.
REQ-004 SHALL have parameter NUM_BANKS, default 2: number of block banks, legal range 2..8.
REQ-005 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  input triplet valid.
REQ-008 SHALL have port in_data  input  3  input triplet {xk,zk,zkp}.
REQ-009 SHALL have port in_trl  input  1  input triplet is termination.
REQ-010 SHALL have port in_length  input  1  block-length flag; sampled on the first triplet of each block.
REQ-011 SHALL have port in_ready  output  1  a bank is free or currently filling.
REQ-012 SHALL have port out_valid / out_ready  output / input  1 each  output handshake.
REQ-013 SHALL have port out_data  output  3  output triplet {xk,zk,zkp}.
REQ-014 SHALL have port out_trl / out_last / out_length  output  1 each  tail flag, last triplet of the block, length flag of the block.
REQ-015 SHALL have port banks_used  output  $clog2(NUM_BANKS+1)  count of completed, unread banks.
REQ-016 SHALL have port overflow_err / framing_err  output  1 each  sticky error flags.

Function
REQ-017 Write side SHALL fill banks round-robin; block size = K + TRL_LEN, where K = in_length ? K_LONG : K_SHORT, latched at write count 0.
REQ-018 Write FSM SHALL have states W_IDLE -> W_DATA on the first accepted triplet, W_DATA -> W_TAIL after K triplets, and W_TAIL -> W_IDLE after TRL_LEN triplets, when the bank is marked complete.
REQ-019 in_ready SHALL be 0 only when all NUM_BANKS banks are complete and unread and no bank is filling.
REQ-020 in_valid while in_ready=0 SHALL drop the triplet and set overflow_err.
REQ-021 Read FSM SHALL have states R_IDLE -> R_DATA when the oldest bank is complete, R_DATA -> R_TAIL after K transfers, and R_TAIL -> R_IDLE (or R_DATA if the next bank is complete) after TRL_LEN transfers.
REQ-022 out_valid SHALL first assert exactly 2 cycles after the accepting edge of the bank's last triplet; back-to-back banks SHALL stream with no bubble.
REQ-023 A transfer SHALL occur when out_valid & out_ready; out_data and flags SHALL hold stable while out_valid & !out_ready.
REQ-024 out_trl SHALL be 1 for the TRL_LEN tail transfers; out_last SHALL be 1 on the final transfer only; out_length SHALL equal the latched flag for the whole block.
REQ-025 banks_used SHALL increment on bank completion and decrement on the out_last transfer; simultaneous completion and release SHALL leave it unchanged.
REQ-026 The bank being read SHALL be freed on its out_last transfer, and in_ready SHALL reflect this in the same cycle.

Reset
REQ-027 rst=1 SHALL immediately force out_valid, out_data, out_trl, out_last, out_length, banks_used, overflow_err and framing_err to 0, both FSMs to idle, and all pointers and counters to 0.
REQ-028 Reset mid-block SHALL discard all partial and complete banks; in_ready SHALL be 1 from the first cycle after rst deasserts.

Configuration
REQ-029 Macro TURBO_OBUF_FRAMING_CHECK_EN defined: framing_err SHALL set (sticky) when in_trl=1 during W_DATA or in_trl=0 during W_TAIL; data is still stored.
REQ-030 Macro TURBO_OBUF_FRAMING_CHECK_EN undefined: in_trl SHALL be ignored and framing_err tied to 0.

Structure
REQ-031 Package turbo_pkg SHALL hold the triplet typedef, the write/read FSM state enums and the default K_SHORT/K_LONG/TRL_LEN constants.
REQ-032 Sub-module turbo_obuf_bank SHALL hold one bank: a (K_LONG+TRL_LEN)x3 RAM with a registered read and the latched length flag; the top instantiates NUM_BANKS of them.

Verification (K_SHORT=40, K_LONG=64, TRL_LEN=4, NUM_BANKS=2)
REQ-033 Bench SHALL cover: one short block with out_ready=1 -> 44 transfers, out_trl on transfers 41-44, out_last on transfer 44, out_length=0, first out_valid 2 cycles after the last input.
REQ-034 Bench SHALL cover: long block then short block back-to-back with out_ready=1 -> 68 then 44 transfers with no idle cycle between them, and out_length 1 then 0.
REQ-035 Bench SHALL cover: three short blocks written with out_ready=0 -> in_ready=0 after block 2 and banks_used=2; block 3 triplets dropped and overflow_err=1.
REQ-036 Bench SHALL cover: random out_ready 30% duty -> output stream bit-exact to input and out_data stable during stalls.
REQ-037 Bench SHALL cover: rst pulsed at write count 20 with one bank complete -> all outputs 0 and banks_used=0; the next block is output correctly.
REQ-038 Bench SHALL cover: with the macro defined, in_trl=1 on triplet 10 -> framing_err=1 held until rst; with it undefined, framing_err=0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared types and default sizing for the turbo output buffer.
package turbo_pkg;

    localparam int K_SHORT_DEF = 1056;
    localparam int K_LONG_DEF  = 6144;
    localparam int TRL_LEN_DEF = 4;

    typedef logic [2:0] triplet_t;  // {xk, zk, zkp}

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_TAIL
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA,
        R_TAIL
    } rd_state_t;

endpackage

// File: rtl/turbo_obuf_bank.sv
// One output-buffer bank: a triplet RAM with registered, enabled read and the
// block's latched length flag.
module turbo_obuf_bank
    import turbo_pkg::*;
#(
    parameter int DEPTH = K_LONG_DEF + TRL_LEN_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  triplet_t      wr_data,
    input  logic          len_we,
    input  logic          len_in,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output triplet_t      rd_data,
    output logic          len
);

    triplet_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only moves on rd_en so it doubles as the stalled output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len <= 1'b0;
        end else if (len_we) begin
            len <= len_in;
        end
    end

endmodule

// File: rtl/turbo_output_buffer.sv
// Multi-bank turbo encoder output buffer: whole blocks are written round-robin and
// streamed out in order. TURBO_OBUF_FRAMING_CHECK_EN enables the in_trl framing check.
module turbo_output_buffer
    import turbo_pkg::*;
#(
    parameter int K_SHORT   = K_SHORT_DEF,
    parameter int K_LONG    = K_LONG_DEF,
    parameter int TRL_LEN   = TRL_LEN_DEF,
    parameter int NUM_BANKS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [2:0]                     in_data,
    input  logic                           in_trl,
    input  logic                           in_length,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2:0]                     out_data,
    output logic                           out_trl,
    output logic                           out_last,
    output logic                           out_length,
    output logic [$clog2(NUM_BANKS+1)-1:0] banks_used,
    output logic                           overflow_err,
    output logic                           framing_err
);

    localparam int DEPTH = K_LONG + TRL_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int CW    = $clog2(NUM_BANKS + 1);

    localparam logic [CNTW-1:0] K_SHORT_C = CNTW'(K_SHORT);
    localparam logic [CNTW-1:0] K_LONG_C  = CNTW'(K_LONG);
    localparam logic [CNTW-1:0] TRL_C     = CNTW'(TRL_LEN);
    localparam logic [BW-1:0]   LAST_BANK = BW'(NUM_BANKS - 1);

    wr_state_t         wr_state_reg, wr_state_next;
    logic [CNTW-1:0]   wr_cnt_reg, wr_cnt_next, wr_cnt_inc;
    logic [BW-1:0]     wr_bank_reg, wr_bank_next;
    logic              wr_long_reg, wr_long_next;
    logic              wr_long_cur, wr_done, accept;
    logic [CNTW-1:0]   wr_k, wr_blk;

    rd_state_t         rd_state_reg, rd_state_next;
    logic [CNTW-1:0]   rd_cnt_reg, rd_cnt_next, rd_cnt_inc;
    logic [BW-1:0]     rd_bank_reg, rd_bank_next, rd_bank_inc;
    logic              rd_long, fetch, load;
    logic [CNTW-1:0]   rd_k, rd_blk;

    logic [NUM_BANKS-1:0] complete_reg;
    logic [NUM_BANKS-1:0] bank_len;
    triplet_t             bank_rd_data [NUM_BANKS];
    logic [CW-1:0]        banks_used_reg;
    logic [BW-1:0]        out_bank_reg;
    logic                 out_valid_reg, out_trl_reg, out_last_reg, out_length_reg;
    logic                 overflow_reg, blk_release;

    // Releasing the bank under read frees space in the same cycle.
    assign blk_release = out_valid_reg & out_ready & out_last_reg;
    assign in_ready    = (banks_used_reg != CW'(NUM_BANKS)) | blk_release;
    assign accept      = in_valid & in_ready;

    assign wr_long_cur = (wr_state_reg == W_IDLE) ? in_length : wr_long_reg;
    assign wr_k        = wr_long_cur ? K_LONG_C : K_SHORT_C;
    assign wr_blk      = wr_k + TRL_C;
    assign wr_cnt_inc  = wr_cnt_reg + CNTW'(1);

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_cnt_next   = wr_cnt_reg;
        wr_bank_next  = wr_bank_reg;
        wr_long_next  = wr_long_reg;
        wr_done       = 1'b0;
        if (accept) begin
            if (wr_state_reg == W_IDLE) begin
                wr_long_next = in_length;
            end
            if (wr_cnt_inc == wr_blk) begin
                wr_state_next = W_IDLE;
                wr_cnt_next   = '0;
                wr_bank_next  = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + BW'(1);
                wr_done       = 1'b1;
            end else begin
                wr_cnt_next   = wr_cnt_inc;
                wr_state_next = (wr_cnt_inc >= wr_k) ? W_TAIL : W_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            wr_cnt_reg   <= '0;
            wr_bank_reg  <= '0;
            wr_long_reg  <= 1'b0;
        end else begin
            wr_state_reg <= wr_state_next;
            wr_cnt_reg   <= wr_cnt_next;
            wr_bank_reg  <= wr_bank_next;
            wr_long_reg  <= wr_long_next;
        end
    end

    assign rd_long     = bank_len[rd_bank_reg];
    assign rd_k        = rd_long ? K_LONG_C : K_SHORT_C;
    assign rd_blk      = rd_k + TRL_C;
    assign rd_cnt_inc  = rd_cnt_reg + CNTW'(1);
    assign rd_bank_inc = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + BW'(1);
    assign load        = ~out_valid_reg | out_ready;

    // Reads run one word ahead of transfers; the bank read register is the output stage.
    always_comb begin
        rd_state_next = rd_state_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_bank_next  = rd_bank_reg;
        fetch         = 1'b0;
        unique case (rd_state_reg)
            R_IDLE: begin
                if (complete_reg[rd_bank_reg]) begin
                    rd_state_next = R_DATA;
                end
            end
            R_DATA, R_TAIL: begin
                if (load) begin
                    fetch = 1'b1;
                    if (rd_cnt_inc == rd_blk) begin
                        rd_cnt_next   = '0;
                        rd_bank_next  = rd_bank_inc;
                        rd_state_next = complete_reg[rd_bank_inc] ? R_DATA : R_IDLE;
                    end else begin
                        rd_cnt_next   = rd_cnt_inc;
                        rd_state_next = (rd_cnt_inc >= rd_k) ? R_TAIL : R_DATA;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_reg   <= R_IDLE;
            rd_cnt_reg     <= '0;
            rd_bank_reg    <= '0;
            out_bank_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_trl_reg    <= 1'b0;
            out_last_reg   <= 1'b0;
            out_length_reg <= 1'b0;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_bank_reg  <= rd_bank_next;
            if (load) begin
                out_valid_reg <= fetch;
                if (fetch) begin
                    out_bank_reg   <= rd_bank_reg;
                    out_trl_reg    <= (rd_cnt_reg >= rd_k);
                    out_last_reg   <= (rd_cnt_inc == rd_blk);
                    out_length_reg <= rd_long;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            complete_reg   <= '0;
            banks_used_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_done && wr_bank_reg == BW'(b)) begin
                    complete_reg[b] <= 1'b1;
                end else if (blk_release && out_bank_reg == BW'(b)) begin
                    complete_reg[b] <= 1'b0;
                end
            end
            unique case ({wr_done, blk_release})
                2'b10:   banks_used_reg <= banks_used_reg + CW'(1);
                2'b01:   banks_used_reg <= banks_used_reg - CW'(1);
                default: banks_used_reg <= banks_used_reg;
            endcase
            if (in_valid && !in_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            turbo_obuf_bank #(
                .DEPTH(DEPTH),
                .AW   (AW)
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (accept && (wr_bank_reg == BW'(gi))),
                .wr_addr(wr_cnt_reg[AW-1:0]),
                .wr_data(in_data),
                .len_we (accept && (wr_bank_reg == BW'(gi)) && (wr_state_reg == W_IDLE)),
                .len_in (in_length),
                .rd_en  (fetch && (rd_bank_reg == BW'(gi))),
                .rd_addr(rd_cnt_reg[AW-1:0]),
                .rd_data(bank_rd_data[gi]),
                .len    (bank_len[gi])
            );
        end
    endgenerate

`ifdef TURBO_OBUF_FRAMING_CHECK_EN
    logic framing_reg;

    // A tail marker inside the data phase, or a missing one in the tail, is a framing slip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            framing_reg <= 1'b0;
        end else if (accept && (in_trl == (wr_cnt_reg < wr_k))) begin
            framing_reg <= 1'b1;
        end
    end
    assign framing_err = framing_reg;
`else
    logic unused_trl;
    assign unused_trl  = in_trl;
    assign framing_err = 1'b0;
`endif

    assign out_valid    = out_valid_reg;
    assign out_data     = bank_rd_data[out_bank_reg];
    assign out_trl      = out_trl_reg;
    assign out_last     = out_last_reg;
    assign out_length   = out_length_reg;
    assign banks_used   = banks_used_reg;
    assign overflow_err = overflow_reg;

endmodule
